// File: rtl/exc_arbiter.sv
// MEM-stage exception prioritiser feeding CP0: picks one exception per cycle and
// suppresses reporting for a short window after an exception/ERET while the pipe flushes.
module exc_arbiter #(
  parameter int         FLUSH_CYCLES = 2,
  parameter logic [4:0] EC_NONE      = 5'h10,
  parameter logic [4:0] EC_ERET      = 5'h11
) (
  input  logic        cpu_clk_75M,
  input  logic        cpu_rst,
  input  logic        mem_valid_i,
  input  logic [31:0] mem_pc_i,
  input  logic        mem_in_delay_i,
  input  logic [5:0]  mem_exc_flags_i,
  input  logic        mem_addr_err_i,
  input  logic        mem_is_store_i,
  input  logic [31:0] mem_addr_i,
  input  logic [31:0] status_i,
  input  logic [31:0] cause_i,
  input  logic        int_time_i,
  input  logic [5:0]  ext_int_i,
  output logic [5:0]  int_o,
  output logic [4:0]  exc_code_o,
  output logic [31:0] exc_epc_o,
  output logic [31:0] exc_badvaddr_o,
  output logic        in_delay_o,
  output logic        holdoff_o
);

  localparam logic [0:0] ST_RUN  = 1'b0;
  localparam logic [0:0] ST_HOLD = 1'b1;

  localparam int CW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LOAD = (FLUSH_CYCLES > 0) ? CW'(FLUSH_CYCLES - 1) : CW'(0);

  logic [5:0]    sync1_q, sync2_q, int_q;
  logic [0:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          active;
  logic          int_pend;

  // Only the IM/IP, IE and EXL fields are consulted.
  logic unused_bits;
  assign unused_bits = ^{status_i[31:16], status_i[7:2], cause_i[31:16], cause_i[7:0]};

  always_ff @(posedge cpu_clk_75M or posedge cpu_rst) begin
    if (cpu_rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
      int_q   <= '0;
      state_q <= ST_RUN;
      cnt_q   <= '0;
    end else begin
      sync1_q <= ext_int_i;
      sync2_q <= sync1_q;
      int_q   <= {sync2_q[5] | int_time_i, sync2_q[4:0]};
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign int_o     = int_q;
  assign holdoff_o = (state_q == ST_HOLD);

  // Reset gates the outputs so CP0 never sees a stray code while rst is held.
  assign active   = (state_q == ST_RUN) & mem_valid_i & ~cpu_rst;
  assign int_pend = (|(cause_i[15:8] & status_i[15:8])) & status_i[0] & ~status_i[1];

  always_comb begin
    exc_code_o     = EC_NONE;
    exc_badvaddr_o = '0;
    if (active) begin
      if (int_pend)                exc_code_o = 5'h00;
      else if (mem_exc_flags_i[0]) begin
        exc_code_o     = 5'h04;
        exc_badvaddr_o = mem_pc_i;
      end
      else if (mem_exc_flags_i[1]) exc_code_o = 5'h0a;
      else if (mem_exc_flags_i[2]) exc_code_o = 5'h08;
      else if (mem_exc_flags_i[3]) exc_code_o = 5'h09;
      else if (mem_exc_flags_i[4]) exc_code_o = 5'h0c;
      else if (mem_addr_err_i) begin
        exc_code_o     = mem_is_store_i ? 5'h05 : 5'h04;
        exc_badvaddr_o = mem_addr_i;
      end
      else if (mem_exc_flags_i[5]) exc_code_o = EC_ERET;
    end
  end

  assign exc_epc_o  = !active ? 32'd0 : (mem_in_delay_i ? mem_pc_i - 32'd4 : mem_pc_i);
  assign in_delay_o = (exc_code_o != EC_NONE) & mem_in_delay_i;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_RUN: begin
        if ((exc_code_o != EC_NONE) && (FLUSH_CYCLES > 0)) begin
          state_d = ST_HOLD;
          cnt_d   = CNT_LOAD;
        end
      end
      default: begin
        if (cnt_q == '0) state_d = ST_RUN;
        else             cnt_d   = cnt_q - 1'b1;
      end
    endcase
  end

endmodule

// File: tb/tb_exc_arbiter.sv
// Self-checking bench for exc_arbiter: vector table plus hand sequences for
// interrupt sync latency, the flush hold-off window and reset during hold-off.
module tb_exc_arbiter;

  localparam logic [4:0] EC_NONE = 5'h10;
  localparam logic [4:0] EC_ERET = 5'h11;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid;
  logic [31:0] pc;
  logic        dly;
  logic [5:0]  flags;
  logic        aerr;
  logic        store;
  logic [31:0] addr;
  logic [31:0] status;
  logic [31:0] cause;
  logic        int_time;
  logic [5:0]  ext_int;
  logic [5:0]  int_o;
  logic [4:0]  code_o;
  logic [31:0] epc_o;
  logic [31:0] bad_o;
  logic        dly_o;
  logic        hold_o;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  exc_arbiter #(.FLUSH_CYCLES(2), .EC_NONE(EC_NONE), .EC_ERET(EC_ERET)) dut (
    .cpu_clk_75M(clk), .cpu_rst(rst),
    .mem_valid_i(valid), .mem_pc_i(pc), .mem_in_delay_i(dly),
    .mem_exc_flags_i(flags), .mem_addr_err_i(aerr), .mem_is_store_i(store),
    .mem_addr_i(addr), .status_i(status), .cause_i(cause),
    .int_time_i(int_time), .ext_int_i(ext_int), .int_o(int_o),
    .exc_code_o(code_o), .exc_epc_o(epc_o), .exc_badvaddr_o(bad_o),
    .in_delay_o(dly_o), .holdoff_o(hold_o)
  );

  typedef struct {
    logic [4:0]  code;
    logic [31:0] epc;
    logic [31:0] bad;
    logic        dly;
    logic        hold;
  } exp_t;

  typedef struct {
    logic        valid;
    logic [31:0] pc;
    logic        dly;
    logic [5:0]  flags;
    logic        aerr;
    logic        store;
    logic [31:0] addr;
    logic [31:0] status;
    logic [31:0] cause;
    exp_t        e;
  } vec_t;

  exp_t sb[$];
  vec_t vecs[13];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic exp_t mk_exp(input logic [4:0] c, input logic [31:0] e, input logic [31:0] b,
                                  input logic d, input logic h);
    exp_t x;
    x.code = c; x.epc = e; x.bad = b; x.dly = d; x.hold = h;
    return x;
  endfunction

  function automatic vec_t mk(input logic v, input logic [31:0] p, input logic d, input logic [5:0] f,
                              input logic ae, input logic st, input logic [31:0] a,
                              input logic [31:0] s, input logic [31:0] c, input exp_t e);
    vec_t x;
    x.valid = v; x.pc = p; x.dly = d; x.flags = f; x.aerr = ae; x.store = st;
    x.addr = a; x.status = s; x.cause = c; x.e = e;
    return x;
  endfunction

  task automatic drive(input vec_t v);
    valid = v.valid; pc = v.pc; dly = v.dly; flags = v.flags; aerr = v.aerr;
    store = v.store; addr = v.addr; status = v.status; cause = v.cause;
  endtask

  task automatic idle();
    valid = 1'b0; flags = '0; aerr = 1'b0; store = 1'b0; dly = 1'b0;
    status = '0; cause = '0;
  endtask

  task automatic pop_check(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      checks++; errors++;
      $display("FAIL %s: scoreboard empty, got code %h expected an entry", tag, code_o);
      return;
    end
    e = sb.pop_front();
    chk({tag, ".code"}, 32'(code_o), 32'(e.code));
    chk({tag, ".epc"},  epc_o, e.epc);
    chk({tag, ".bad"},  bad_o, e.bad);
    chk({tag, ".dly"},  32'(dly_o), 32'(e.dly));
    chk({tag, ".hold"}, 32'(hold_o), 32'(e.hold));
  endtask

  initial begin
    vecs[0]  = mk(1, 32'hBFC0_0100, 0, 6'b000000, 0, 0, 0, 32'h0000_0401, 32'h0000_0400,
                  mk_exp(5'h00, 32'hBFC0_0100, 0, 0, 0));
    vecs[1]  = mk(1, 32'hBFC0_0100, 0, 6'b000000, 0, 0, 0, 32'h0000_0403, 32'h0000_0400,
                  mk_exp(EC_NONE, 32'hBFC0_0100, 0, 0, 0));
    vecs[2]  = mk(1, 32'h8000_0010, 1, 6'b010010, 0, 0, 0, 0, 0,
                  mk_exp(5'h0a, 32'h8000_000C, 0, 1, 0));
    vecs[3]  = mk(1, 32'h0040_0000, 0, 6'b000000, 1, 1, 32'h1000_0003, 0, 0,
                  mk_exp(5'h05, 32'h0040_0000, 32'h1000_0003, 0, 0));
    vecs[4]  = mk(1, 32'h0000_0002, 0, 6'b000001, 1, 0, 32'h0000_1234, 0, 0,
                  mk_exp(5'h04, 32'h0000_0002, 32'h0000_0002, 0, 0));
    vecs[5]  = mk(1, 32'h0040_0010, 0, 6'b000000, 1, 0, 32'h0000_2001, 0, 0,
                  mk_exp(5'h04, 32'h0040_0010, 32'h0000_2001, 0, 0));
    vecs[6]  = mk(0, 32'h0040_0020, 1, 6'b000100, 0, 0, 0, 0, 0,
                  mk_exp(EC_NONE, 0, 0, 0, 0));
    vecs[7]  = mk(1, 32'h0040_0030, 0, 6'b011000, 0, 0, 0, 0, 0,
                  mk_exp(5'h09, 32'h0040_0030, 0, 0, 0));
    vecs[8]  = mk(1, 32'h0040_0040, 1, 6'b010000, 0, 0, 0, 0, 0,
                  mk_exp(5'h0c, 32'h0040_003C, 0, 1, 0));
    vecs[9]  = mk(1, 32'h0040_0050, 0, 6'b100000, 1, 0, 32'h0000_3002, 0, 0,
                  mk_exp(5'h04, 32'h0040_0050, 32'h0000_3002, 0, 0));
    vecs[10] = mk(1, 32'h0000_0100, 1, 6'b100000, 0, 0, 0, 0, 0,
                  mk_exp(EC_ERET, 32'h0000_00FC, 0, 1, 0));
    vecs[11] = mk(1, 32'h0040_0060, 0, 6'b000100, 0, 0, 0, 32'h0000_0400, 32'h0000_0400,
                  mk_exp(5'h08, 32'h0040_0060, 0, 0, 0));
    vecs[12] = mk(1, 32'h0000_0000, 1, 6'b000001, 0, 0, 0, 32'h0000_8001, 32'h0000_8000,
                  mk_exp(5'h00, 32'hFFFF_FFFC, 0, 1, 0));

    rst = 1'b1; int_time = 1'b0; ext_int = '0; addr = '0; pc = 32'h0040_0000;
    idle();
    valid = 1'b1; flags = 6'b000100;
    #12;
    chk("rst.code", 32'(code_o), 32'(EC_NONE));
    chk("rst.epc", epc_o, 32'd0);
    chk("rst.hold", 32'(hold_o), 32'd0);
    chk("rst.int", 32'(int_o), 32'd0);
    @(posedge clk); #1;
    chk("rst.code2", 32'(code_o), 32'(EC_NONE));
    idle();
    @(negedge clk); rst = 1'b0;

    // Interrupt synchroniser latency
    @(posedge clk); #1 ext_int = 6'b000100;
    for (int k = 1; k <= 3; k++) begin
      @(posedge clk); #1;
      chk($sformatf("int_sync.e%0d", k), 32'(int_o[2]), (k == 3) ? 32'd1 : 32'd0);
    end
    ext_int = '0;
    chk("int_time.before", 32'(int_o[5]), 32'd0);
    int_time = 1'b1;
    @(posedge clk); #1;
    chk("int_time.after", 32'(int_o[5]), 32'd1);
    int_time = 1'b0;
    repeat (4) @(posedge clk);

    // Vector table; idle cycles between entries let any hold-off window drain
    for (int i = 0; i < 13; i++) begin
      @(posedge clk); #1;
      drive(vecs[i]);
      sb.push_back(vecs[i].e);
      @(negedge clk);
      pop_check($sformatf("vec%0d", i));
      @(posedge clk); #1 idle();
      repeat (3) @(posedge clk);
    end

    // ERET then Syscall on the following three cycles
    @(posedge clk); #1;
    valid = 1'b1; pc = 32'h0000_0040; dly = 1'b0; flags = 6'b100000;
    sb.push_back(mk_exp(EC_ERET, 32'h0000_0040, 0, 0, 0));
    @(negedge clk); pop_check("eret.c0");
    @(posedge clk); #1 flags = 6'b000100;
    sb.push_back(mk_exp(EC_NONE, 0, 0, 0, 1));
    @(negedge clk); pop_check("eret.c1");
    @(posedge clk); #1;
    sb.push_back(mk_exp(EC_NONE, 0, 0, 0, 1));
    @(negedge clk); pop_check("eret.c2");
    @(posedge clk); #1;
    sb.push_back(mk_exp(5'h08, 32'h0000_0040, 0, 0, 0));
    @(negedge clk); pop_check("eret.c3");
    @(posedge clk); #1 idle();
    repeat (3) @(posedge clk);

    // Reset asserted inside the hold-off window
    @(posedge clk); #1;
    valid = 1'b1; pc = 32'h0000_0080; flags = 6'b000100;
    sb.push_back(mk_exp(5'h08, 32'h0000_0080, 0, 0, 0));
    @(negedge clk); pop_check("rsthold.c0");
    @(posedge clk); #1;
    chk("rsthold.in_hold", 32'(hold_o), 32'd1);
    rst = 1'b1;
    #1;
    chk("rsthold.hold", 32'(hold_o), 32'd0);
    chk("rsthold.code", 32'(code_o), 32'(EC_NONE));
    @(negedge clk); rst = 1'b0;
    #1;
    sb.push_back(mk_exp(5'h08, 32'h0000_0080, 0, 0, 0));
    pop_check("rsthold.after");
    @(posedge clk); #1 idle();
    repeat (3) @(posedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/exc_arbiter.md
Name: exc_arbiter

Overview:
- MEM-stage exception prioritiser that sits directly upstream of the CP0 block.
- Collects per-instruction exception flags, the address-error info, the synchronised external interrupts and the CP0 Status/Cause state.
- Each cycle it presents a single exc_code/EPC/BadVAddr/in-delay tuple to CP0.
- After any exception or ERET it enforces a flush hold-off window, so that squashed instructions cannot raise a second exception.

Parameters:
- FLUSH_CYCLES, 2, cycles after an issued exception/ERET during which reporting is suppressed (0 = no hold-off).
- EC_NONE, 5'h10, "no exception" code, matches CP0 EC_None.
- EC_ERET, 5'h11, ERET request code, matches CP0 EC_Eret.

Ports:
- cpu_clk_75M  in  1  core clock.
- cpu_rst  in  1  asynchronous, active-high reset.
- mem_valid_i  in  1  MEM stage holds a real (non-bubble) instruction.
- mem_pc_i  in  32  PC of the MEM instruction.
- mem_in_delay_i  in  1  MEM instruction is in a branch delay slot.
- mem_exc_flags_i  in  6  one-hot-or-more flags: [0] fetch AdEL, [1] RI, [2] Syscall, [3] Break, [4] Ov, [5] ERET.
- mem_addr_err_i  in  1  data access misaligned.
- mem_is_store_i  in  1  data access is a store.
- mem_addr_i  in  32  data access virtual address.
- status_i  in  32  CP0 Status.
- cause_i  in  32  CP0 Cause.
- int_time_i  in  1  CP0 timer interrupt.
- ext_int_i  in  6  asynchronous external interrupt lines.
- int_o  out  6  synchronised interrupt vector to CP0 int_i.
- exc_code_o  out  5  to CP0 exc_code_i.
- exc_epc_o  out  32  to CP0 exc_epc_i.
- exc_badvaddr_o  out  32  to CP0 exc_badvaddr_i.
- in_delay_o  out  1  to CP0 in_delay_i.
- holdoff_o  out  1  hold-off window active.

Behaviour:
- Reset (async, cpu_rst=1):
  - sync flops cleared; state=RUN; counter=0; int_o=0.
  - exc_code_o=EC_NONE; exc_epc_o=0; exc_badvaddr_o=0; in_delay_o=0; holdoff_o=0.
  - Reset asserted mid-hold-off aborts the window immediately.
- Interrupt synchronisation:
  - ext_int_i passes through a 2-flop synchroniser → s2[5:0].
  - int_o = {s2[5] | int_time_i, s2[4:0]}, registered: 3-cycle latency from ext_int_i, 1 cycle from int_time_i.
- Interrupt pending (combinational): int_pend = |(cause_i[15:8] & status_i[15:8]) & status_i[0] & ~status_i[1].
- Exception code selection (combinational, fixed priority, only when state==RUN and mem_valid_i=1):
  - Int (5'h00) > fetch AdEL (5'h04) > RI (5'h0a) > Sys (5'h08) > Bp (5'h09) > Ov (5'h0c).
  - Then data error: AdES (5'h05) if mem_is_store_i, else AdEL (5'h04).
  - Then ERET (EC_ERET).
  - Otherwise EC_NONE.
  - If mem_valid_i=0 or state==HOLD: EC_NONE; EPC, BadVAddr and in_delay outputs forced to 0.
- EPC and delay-slot flag:
  - exc_epc_o = mem_in_delay_i ? mem_pc_i − 32'd4 : mem_pc_i (modulo 2^32).
  - in_delay_o = mem_in_delay_i when a code other than EC_NONE is presented, else 0.
- BadVAddr:
  - fetch AdEL selected → mem_pc_i.
  - data AdEL/AdES selected → mem_addr_i.
  - otherwise → 0.
- State machine:
  - RUN: if exc_code_o≠EC_NONE (ERET included) and FLUSH_CYCLES>0 → HOLD, counter=FLUSH_CYCLES−1.
  - HOLD: holdoff_o=1 and all exceptions are masked. When counter==0 → RUN; otherwise counter decrements.
  - An exception arriving on the cycle HOLD exits is masked. It is first eligible in the following RUN cycle.
- Simultaneous flags: exactly one code is reported, the highest-priority one. Lower flags are dropped, not queued.
- Interrupt with EXL=1 or IE=0 is not taken and not latched. It is re-evaluated each cycle from status_i/cause_i.

Test Plan:
- Reset, then raise ext_int_i[2] → int_o[2]=1 on the 3rd rising edge; outputs EC_NONE throughout reset.
- status_i=32'h0000_0401, cause_i[10]=1, mem_valid_i=1, pc=32'hBFC0_0100, delay=0 → code 5'h00, epc 32'hBFC0_0100. Repeat with status_i[1]=1 → EC_NONE.
- Flags RI+Ov together, pc=32'h8000_0010, in_delay=1 → code 5'h0a, epc 32'h8000_000C, in_delay_o=1.
- mem_addr_err_i=1, store=1, addr=32'h1000_0003 → code 5'h05, badvaddr 32'h1000_0003. Fetch AdEL at pc=32'h0000_0002 → badvaddr 32'h0000_0002.
- ERET, then Syscall flag on each of the next 3 cycles with FLUSH_CYCLES=2 → ERET, then EC_NONE, EC_NONE (holdoff_o=1), then 5'h08.
- Assert cpu_rst during HOLD → holdoff_o=0 immediately; after release, a Syscall is reported the first valid cycle.
